io_write_buffer: RTL and testbench
==================================

IO_WRITE_BUFFER -- requirements
Module: io_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, minimum 4.
REQ-002 SHALL have parameter MARGIN, default 2, meaning free entries still held when io_buffer_full asserts, to absorb CPU writes already in flight.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port rdy_in, input, 1 bit: when low, pushes are ignored.
REQ-006 SHALL have port mem_a, input, 32 bits: CPU address bus; only bits 17:0 are decoded.
REQ-007 SHALL have port mem_dout, input, 8 bits: CPU write-data byte.
REQ-008 SHALL have port mem_wr, input, 1 bit: CPU write strobe, 1 = write.
REQ-009 SHALL have port tx_ready, input, 1 bit: the UART transmitter accepts a byte.
REQ-010 SHALL have port tx_valid, output, 1 bit: tx_data holds a valid byte.
REQ-011 SHALL have port tx_data, output, 8 bits: byte at the FIFO head.
REQ-012 SHALL have port io_buffer_full, output, 1 bit: back-pressure to the CPU.
REQ-013 SHALL have port overflow, output, 1 bit: sticky error flag.
REQ-014 SHALL have port prog_end, output, 1 bit: one-cycle pulse when the drain completes.

Function
REQ-015 SHALL define push as rdy_in && mem_wr && mem_a[17:0]==18'h30000 && state==RUN.
REQ-016 SHALL define halt request as rdy_in && mem_wr && mem_a[17:0]==18'h30004.
REQ-017 SHALL ignore all other addresses and all reads.
REQ-018 SHALL define pop as tx_valid && tx_ready; pop SHALL be independent of rdy_in.
REQ-019 SHALL, on push with count<DEPTH, write mem_dout at the write pointer; the pointer SHALL wrap modulo DEPTH.
REQ-020 SHALL, on push with count==DEPTH and no pop in the same cycle, drop the byte and set overflow until reset.
REQ-021 SHALL, on push and pop in the same cycle, leave count unchanged; this includes the full case, where no overflow occurs.
REQ-022 SHALL drive tx_valid = (count!=0) and tx_data = mem[rd_ptr] combinationally from registers.
REQ-023 SHALL make a pushed byte appear on tx_data one cycle after the push edge when the FIFO was empty.
REQ-024 SHALL register io_buffer_full as (next_count >= DEPTH-MARGIN) || state!=RUN.
REQ-025 SHALL hold count with width log2(DEPTH)+1; pointers SHALL be log2(DEPTH) bits.
REQ-026 SHALL implement FSM states RUN, DRAIN and DONE.
REQ-027 SHALL transition RUN to DRAIN on a halt request.
REQ-028 SHALL transition DRAIN to DONE when count==0 and no push is pending; prog_end SHALL be high for exactly that one cycle.
REQ-029 SHALL make DONE absorbing until reset; in DONE, pushes and halt requests SHALL be ignored.
REQ-030 SHALL treat a halt request in DRAIN or DONE as a no-op.
REQ-031 SHALL, when push and halt are in the same cycle (impossible on an 8-bit bus but decoded anyway), give halt priority and drop the push without setting overflow.

Reset
REQ-032 SHALL, while rst_in is low, asynchronously clear pointers and count, set state=RUN, clear overflow, and drive tx_valid=0, io_buffer_full=0 and prog_end=0.
REQ-033 SHALL, on reset mid-transfer, discard the FIFO contents; tx_data becomes don't-care while tx_valid=0.
REQ-034 SHALL leave the storage array unreset.

Structure
REQ-035 SHALL place the IO address constants (IO_DATA_ADDR 18'h30000, IO_END_ADDR 18'h30004) and the FSM state encodings in global_params.v.
REQ-036 SHALL implement the FIFO as one sub-module, byte_fifo (parameter DEPTH, push/pop/count/full/empty), with the FSM and decoding in io_write_buffer.

Verification
REQ-037 SHALL cover: push 0x41, 0x42, 0x43 with tx_ready=1 -> tx_data 0x41, 0x42, 0x43 on consecutive cycles; first tx_valid one cycle after the first push.
REQ-038 SHALL cover: tx_ready=0 and 14 pushes with DEPTH=16, MARGIN=2 -> io_buffer_full high at the edge of the 14th push; 16 pushes -> count=16, overflow=0; 17th push -> overflow=1, count stays 16.
REQ-039 SHALL cover: FIFO full, tx_ready=1 and a push in the same cycle -> count stays 16, overflow=0, the new byte is emitted last.
REQ-040 SHALL cover: 5 bytes queued, write to 0x30004, tx_ready=1 -> io_buffer_full=1 at once; prog_end pulses exactly once, in the cycle after the 5th pop; a later push to 0x30000 is ignored.
REQ-041 SHALL cover: rdy_in=0 during a write to 0x30000 -> no push; a queued byte is still popped.
REQ-042 SHALL cover: rst_in low mid-drain with 3 bytes queued -> tx_valid=0, state RUN and count 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_write_buffer_pkg.sv
// Shared constants for the IO write buffer: decoded CPU addresses and FSM encoding.
package io_write_buffer_pkg;

    localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [17:0] IO_END_ADDR  = 18'h30004;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/io_write_buffer_if.sv
// CPU write bus plus UART byte stream seen by the IO write buffer.
interface io_write_buffer_if;

    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        io_buffer_full;
    logic        overflow;
    logic        prog_end;

    modport master (
        output rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
        input  tx_valid, tx_data, io_buffer_full, overflow, prog_end
    );

    modport slave (
        input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready,
        output tx_valid, tx_data, io_buffer_full, overflow, prog_end
    );

endinterface

// File: rtl/io_write_buffer_byte_fifo.sv
// Byte FIFO with registered pointers/count and an unreset storage array.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_next_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign w_rd_en = i_pop && !o_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    always_comb begin
        o_next_count = r_count;
        if (w_wr_en && !w_rd_en) begin
            o_next_count = r_count + 1'b1;
        end else if (!w_wr_en && w_rd_en) begin
            o_next_count = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= o_next_count;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/io_write_buffer.sv
// CPU-to-UART write buffer: decodes IO writes, queues bytes, drains on halt request.
// States: RUN accepts bytes | DRAIN flushes queue, no pushes | DONE halted until reset.
module io_write_buffer
    import io_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int MARGIN = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    io_write_buffer_if.slave  bus
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [AW:0] FULL_THRESH = (AW+1)'(DEPTH - MARGIN);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_halt;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [AW:0] w_count;
    logic [AW:0] w_next_count;
    logic [7:0]  w_fifo_data;
    logic        w_prog_end;
    logic        r_overflow;
    logic        r_io_full;
    logic        w_unused_addr;

    assign w_unused_addr = ^bus.mem_a[31:18];

    // Halt wins over a data write in the same cycle; the dropped byte is not an overflow.
    assign w_halt = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:0] == IO_END_ADDR);
    assign w_push = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:0] == IO_DATA_ADDR)
                    && (r_state == ST_RUN) && !w_halt;
    assign w_pop  = !w_fifo_empty && bus.tx_ready;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_data       (bus.mem_dout),
        .o_data       (w_fifo_data),
        .o_count      (w_count),
        .o_next_count (w_next_count),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (w_halt) w_next_state = ST_DRAIN;
            ST_DRAIN: if ((w_count == '0) && !w_push) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_DONE;
            default:  w_next_state = ST_RUN;
        endcase
    end

    always_comb begin
        w_prog_end = 1'b0;
        if ((r_state == ST_DRAIN) && (w_count == '0) && !w_push) begin
            w_prog_end = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_overflow <= 1'b0;
            r_io_full  <= 1'b0;
        end else begin
            if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
            r_io_full <= (w_next_count >= FULL_THRESH) || (w_next_state != ST_RUN);
        end
    end

    assign bus.tx_valid       = !w_fifo_empty;
    assign bus.tx_data        = w_fifo_data;
    assign bus.io_buffer_full = r_io_full;
    assign bus.overflow       = r_overflow;
    assign bus.prog_end       = w_prog_end;

endmodule

// File: tb/tb_io_write_buffer.sv
// Bench for io_write_buffer: directed scenarios plus random traffic against a queue model.
module tb_io_write_buffer;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;

    logic clk;
    logic rst_n;

    io_write_buffer_if bus();

    io_write_buffer #(.DEPTH(DEPTH), .MARGIN(MARGIN)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_full;
    int         m_mode;   // 0 run, 1 drain, 2 done

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic rdy, input logic wr, input logic [31:0] a,
                         input logic [7:0] d, input logic txr);
        bus.rdy_in   = rdy;
        bus.mem_wr   = wr;
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.tx_ready = txr;
    endtask

    task automatic idle(input logic txr);
        drive(1'b1, 1'b0, 32'h0, 8'h00, txr);
    endtask

    task automatic push_b(input logic [7:0] d, input logic txr);
        drive(1'b1, 1'b1, 32'h0003_0000, d, txr);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ovf  = 1'b0;
        m_full = 1'b0;
        m_mode = 0;
    endtask

    // Apply the current inputs to the model for the coming edge, then move to the next low phase.
    task automatic tick();
        int sz;
        bit pop, halt, push;
        sz   = m_q.size();
        pop  = (sz != 0) && bus.tx_ready;
        halt = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:0] == 18'h30004);
        push = bus.rdy_in && bus.mem_wr && (bus.mem_a[17:0] == 18'h30000) && (m_mode == 0) && !halt;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) m_q.push_back(bus.mem_dout);
            else m_ovf = 1'b1;
        end
        if (m_mode == 0 && halt) m_mode = 1;
        else if (m_mode == 1 && sz == 0) m_mode = 2;
        m_full = (m_q.size() >= DEPTH - MARGIN) || (m_mode != 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(1'b0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle(1'b0);
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.tx_valid); end
        total++; if (bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.io_buffer_full); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        total++; if (bus.prog_end !== 1'b0) begin bad++; $display("FAIL reset_prog_end: got %b want 0", bus.prog_end); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [7:0] seq [3];
        seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
        do_reset();
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL stream_pre_valid: got %b want 0", bus.tx_valid); end
        for (int i = 0; i < 3; i++) begin
            push_b(seq[i], 1'b1);
            tick();
            total++; if (bus.tx_valid !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %b want 1", i, bus.tx_valid); end
            total++; if (bus.tx_data !== seq[i]) begin bad++; $display("FAIL stream_data%0d: got %h want %h", i, bus.tx_data, seq[i]); end
        end
        idle(1'b1);
        tick();
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid: got %b want 0", bus.tx_valid); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            push_b(8'(i), 1'b0);
            tick();
            total++; if (bus.io_buffer_full !== (i >= 14)) begin bad++; $display("FAIL fill_full%0d: got %b want %b", i, bus.io_buffer_full, (i >= 14)); end
            total++; if (bus.overflow !== (i >= 17)) begin bad++; $display("FAIL fill_ovf%0d: got %b want %b", i, bus.overflow, (i >= 17)); end
        end
        for (int k = 0; k < 16; k++) begin
            total++; if (bus.tx_data !== 8'(k + 1) || bus.tx_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", k, bus.tx_valid, bus.tx_data, 8'(k + 1)); end
            idle(1'b1);
            tick();
        end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", bus.tx_valid); end
        total++; if (bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL ovf_full_clear: got %b want 0", bus.io_buffer_full); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            push_b(8'h10 + 8'(i), 1'b0);
            tick();
        end
        push_b(8'hEE, 1'b1);
        tick();
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf: got %b want 0", bus.overflow); end
        total++; if (bus.io_buffer_full !== 1'b1) begin bad++; $display("FAIL pp_full: got %b want 1", bus.io_buffer_full); end
        for (int k = 0; k < 16; k++) begin
            exp = (k < 15) ? 8'h12 + 8'(k) : 8'hEE;
            total++; if (bus.tx_data !== exp || bus.tx_valid !== 1'b1) begin bad++; $display("FAIL pp_drain%0d: got %b/%h want 1/%h", k, bus.tx_valid, bus.tx_data, exp); end
            idle(1'b1);
            tick();
        end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL pp_empty: got %b want 0", bus.tx_valid); end
    endtask

    task automatic test_halt_drain();
        int pulses, at;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_b(8'hC0 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'hFF03_0004, 8'h00, 1'b1);
        tick();
        total++; if (bus.io_buffer_full !== 1'b1) begin bad++; $display("FAIL halt_full: got %b want 1", bus.io_buffer_full); end
        pulses = 0;
        at = -1;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) push_b(8'h99, 1'b1);
            else idle(1'b1);
            tick();
            total++; if (bus.prog_end !== (m_mode == 1 && m_q.size() == 0)) begin bad++; $display("FAIL halt_prog_end%0d: got %b want %b", i, bus.prog_end, (m_mode == 1 && m_q.size() == 0)); end
            if (bus.prog_end === 1'b1) begin pulses++; at = i; end
        end
        total++; if (pulses != 1 || at != 3) begin bad++; $display("FAIL halt_pulse: got %0d pulses at %0d want 1 at 3", pulses, at); end
        push_b(8'h55, 1'b1);
        tick();
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL done_push: got %b want 0", bus.tx_valid); end
        total++; if (bus.io_buffer_full !== 1'b1) begin bad++; $display("FAIL done_full: got %b want 1", bus.io_buffer_full); end
    endtask

    task automatic test_rdy_low();
        do_reset();
        push_b(8'hA5, 1'b0);
        tick();
        total++; if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL rdy_head: got %h want a5", bus.tx_data); end
        drive(1'b0, 1'b1, 32'h0003_0000, 8'h5A, 1'b1);
        tick();
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rdy_nopush: got %b want 0", bus.tx_valid); end
        drive(1'b0, 1'b1, 32'h0003_0004, 8'h00, 1'b0);
        tick();
        push_b(8'h3C, 1'b0);
        tick();
        total++; if (bus.tx_data !== 8'h3C || bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL rdy_nohalt: got %h/%b want 3c/0", bus.tx_data, bus.io_buffer_full); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_b(8'h60 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h00, 1'b0);
        tick();
        total++; if (bus.tx_valid !== 1'b1 || bus.io_buffer_full !== 1'b1) begin bad++; $display("FAIL mid_pre: got %b/%b want 1/1", bus.tx_valid, bus.io_buffer_full); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", bus.tx_valid); end
        total++; if (bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL mid_full: got %b want 0", bus.io_buffer_full); end
        idle(1'b0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        push_b(8'h77, 1'b0);
        tick();
        total++; if (bus.tx_data !== 8'h77 || bus.tx_valid !== 1'b1 || bus.io_buffer_full !== 1'b0) begin bad++; $display("FAIL mid_run: got %b/%h/%b want 1/77/0", bus.tx_valid, bus.tx_data, bus.io_buffer_full); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int sel, thr;
        bit  exp_pe;
        for (int s = 0; s < 3; s++) begin
            do_reset();
            thr = (s == 0) ? 25 : (s == 1) ? 50 : 90;
            for (int c = 0; c < 250; c++) begin
                exp_pe = (m_mode == 1) && (m_q.size() == 0);
                total++; if (bus.tx_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid s%0d c%0d: got %b want %b", s, c, bus.tx_valid, (m_q.size() != 0)); end
                if (m_q.size() != 0) begin
                    total++; if (bus.tx_data !== m_q[0]) begin bad++; $display("FAIL rnd_data s%0d c%0d: got %h want %h", s, c, bus.tx_data, m_q[0]); end
                end
                total++; if (bus.io_buffer_full !== m_full) begin bad++; $display("FAIL rnd_full s%0d c%0d: got %b want %b", s, c, bus.io_buffer_full, m_full); end
                total++; if (bus.overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf s%0d c%0d: got %b want %b", s, c, bus.overflow, m_ovf); end
                total++; if (bus.prog_end !== exp_pe) begin bad++; $display("FAIL rnd_prog_end s%0d c%0d: got %b want %b", s, c, bus.prog_end, exp_pe); end
                a   = $urandom();
                sel = $urandom_range(0, 99);
                if (sel < 55) a[17:0] = 18'h30000;
                else if (sel < 56 && c > 150) a[17:0] = 18'h30004;
                else a[17:0] = 18'h30001 + 18'(sel);
                drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, a,
                      8'($urandom()), $urandom_range(0, 99) < thr);
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_overflow();
        test_full_push_pop();
        test_halt_drain();
        test_rdy_low();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
